// File: rtl/axi_dma_rd_desc_arb.sv
// Round-robin arbiter sharing one DMA read-descriptor input among PORTS requesters,
// with per-port outstanding caps and tag-prefix based status demultiplexing.
module axi_dma_rd_desc_arb #(
    parameter int PORTS           = 4,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 20,
    parameter int S_TAG_WIDTH     = 8,
    parameter int CL_PORTS        = $clog2(PORTS),
    parameter int M_TAG_WIDTH     = S_TAG_WIDTH + CL_PORTS,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [PORTS*AXI_ADDR_WIDTH-1:0] s_axis_read_desc_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]      s_axis_read_desc_len,
    input  logic [PORTS*S_TAG_WIDTH-1:0]    s_axis_read_desc_tag,
    input  logic [PORTS-1:0]                s_axis_read_desc_valid,
    output logic [PORTS-1:0]                s_axis_read_desc_ready,

    output logic [AXI_ADDR_WIDTH-1:0]       m_axis_read_desc_addr,
    output logic [LEN_WIDTH-1:0]            m_axis_read_desc_len,
    output logic [M_TAG_WIDTH-1:0]          m_axis_read_desc_tag,
    output logic                            m_axis_read_desc_valid,
    input  logic                            m_axis_read_desc_ready,

    input  logic [M_TAG_WIDTH-1:0]          s_axis_read_desc_status_tag,
    input  logic [3:0]                      s_axis_read_desc_status_error,
    input  logic                            s_axis_read_desc_status_valid,

    output logic [PORTS*S_TAG_WIDTH-1:0]    m_axis_read_desc_status_tag,
    output logic [PORTS*4-1:0]              m_axis_read_desc_status_error,
    output logic [PORTS-1:0]                m_axis_read_desc_status_valid,

    input  logic                            enable
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned NP = PORTS;

    logic [CNT_W-1:0]    cnt [PORTS];
    logic [CL_PORTS-1:0] last_grant;
    logic [PORTS-1:0]    eligible;
    logic                reg_free;
    logic                grant_found;
    logic [CL_PORTS-1:0] grant_idx;
    logic                grant;
    logic [CL_PORTS-1:0] stat_idx;
    logic                stat_hit;
    logic [PORTS-1:0]    cnt_inc;
    logic [PORTS-1:0]    cnt_dec;

    always_comb begin
        eligible = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            eligible[p] = s_axis_read_desc_valid[p] && (cnt[p] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    // Rotating search: first eligible port after the last one granted.
    always_comb begin
        int unsigned idx;
        logic [CL_PORTS-1:0] cand;
        idx         = 0;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 1; i <= NP; i++) begin
            idx  = (32'(last_grant) + i) % NP;
            cand = CL_PORTS'(idx);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign reg_free = !m_axis_read_desc_valid || m_axis_read_desc_ready;
    assign grant    = grant_found && reg_free && enable && !rst;

    always_comb begin
        s_axis_read_desc_ready = '0;
        if (grant) begin
            s_axis_read_desc_ready[grant_idx] = 1'b1;
        end
    end

    assign stat_idx = s_axis_read_desc_status_tag[M_TAG_WIDTH-1 -: CL_PORTS];
    assign stat_hit = s_axis_read_desc_status_valid &&
                      ({1'b0, stat_idx} < (CL_PORTS+1)'(PORTS));

    // A decrement at zero is suppressed so the counter never wraps.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            cnt_inc[p] = grant && (grant_idx == CL_PORTS'(p));
            cnt_dec[p] = stat_hit && (stat_idx == CL_PORTS'(p)) && (cnt[p] != '0);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < NP; p++) begin
            if (rst) begin
                cnt[p] <= '0;
            end else if (cnt_inc[p] && !cnt_dec[p]) begin
                cnt[p] <= cnt[p] + 1'b1;
            end else if (cnt_dec[p] && !cnt_inc[p]) begin
                cnt[p] <= cnt[p] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_read_desc_valid <= 1'b0;
            m_axis_read_desc_addr  <= '0;
            m_axis_read_desc_len   <= '0;
            m_axis_read_desc_tag   <= '0;
            last_grant             <= CL_PORTS'(PORTS - 1);
        end else if (grant) begin
            m_axis_read_desc_valid <= 1'b1;
            m_axis_read_desc_addr  <= s_axis_read_desc_addr[grant_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            m_axis_read_desc_len   <= s_axis_read_desc_len[grant_idx*LEN_WIDTH +: LEN_WIDTH];
            m_axis_read_desc_tag   <= {grant_idx, s_axis_read_desc_tag[grant_idx*S_TAG_WIDTH +: S_TAG_WIDTH]};
            last_grant             <= grant_idx;
        end else if (m_axis_read_desc_ready) begin
            m_axis_read_desc_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_read_desc_status_valid <= '0;
            m_axis_read_desc_status_tag   <= '0;
            m_axis_read_desc_status_error <= '0;
        end else begin
            m_axis_read_desc_status_valid <= '0;
            if (stat_hit) begin
                m_axis_read_desc_status_valid[stat_idx] <= 1'b1;
                m_axis_read_desc_status_tag[stat_idx*S_TAG_WIDTH +: S_TAG_WIDTH] <=
                    s_axis_read_desc_status_tag[S_TAG_WIDTH-1:0];
                m_axis_read_desc_status_error[stat_idx*4 +: 4] <= s_axis_read_desc_status_error;
            end
        end
    end

endmodule

// File: tb/tb_axi_dma_rd_desc_arb.sv
// Bench for axi_dma_rd_desc_arb: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_axi_dma_rd_desc_arb;

    localparam int PORTS = 4;
    localparam int AW    = 16;
    localparam int LW    = 20;
    localparam int TW    = 8;
    localparam int MTW   = 10;
    localparam int MAXO  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [PORTS*AW-1:0] s_addr;
    logic [PORTS*LW-1:0] s_len;
    logic [PORTS*TW-1:0] s_tag;
    logic [PORTS-1:0]    s_valid;
    logic [PORTS-1:0]    s_ready;
    logic [AW-1:0]       m_addr;
    logic [LW-1:0]       m_len;
    logic [MTW-1:0]      m_tag;
    logic                m_valid;
    logic                m_ready;
    logic [MTW-1:0]      st_tag_in;
    logic [3:0]          st_err_in;
    logic                st_valid_in;
    logic [PORTS*TW-1:0] st_tag_out;
    logic [PORTS*4-1:0]  st_err_out;
    logic [PORTS-1:0]    st_valid_out;
    logic                enable;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int             mcnt [PORTS];
    int             mlast;
    logic           mv;
    logic [AW-1:0]  maddr;
    logic [LW-1:0]  mlen;
    logic [MTW-1:0] mtag;
    logic [3:0]     msv;
    logic [TW-1:0]  mstag [PORTS];
    logic [3:0]     mserr [PORTS];

    axi_dma_rd_desc_arb #(
        .PORTS(PORTS), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .S_TAG_WIDTH(TW),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_read_desc_addr(s_addr), .s_axis_read_desc_len(s_len),
        .s_axis_read_desc_tag(s_tag), .s_axis_read_desc_valid(s_valid),
        .s_axis_read_desc_ready(s_ready),
        .m_axis_read_desc_addr(m_addr), .m_axis_read_desc_len(m_len),
        .m_axis_read_desc_tag(m_tag), .m_axis_read_desc_valid(m_valid),
        .m_axis_read_desc_ready(m_ready),
        .s_axis_read_desc_status_tag(st_tag_in), .s_axis_read_desc_status_error(st_err_in),
        .s_axis_read_desc_status_valid(st_valid_in),
        .m_axis_read_desc_status_tag(st_tag_out), .m_axis_read_desc_status_error(st_err_out),
        .m_axis_read_desc_status_valid(st_valid_out),
        .enable(enable)
    );

    always #5 clk = ~clk;

    function automatic int exp_grant();
        if (rst || !enable || (mv && !m_ready)) return -1;
        for (int i = 1; i <= PORTS; i++) begin
            int p;
            p = (mlast + i) % PORTS;
            if (s_valid[p] && mcnt[p] < MAXO) return p;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        int g;
        r = '0;
        g = exp_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock and move the reference model to the post-edge state.
    task automatic tick();
        int g;
        int sp;
        bit dec;
        g = exp_grant();
        @(posedge clk);
        if (rst) begin
            for (int p = 0; p < PORTS; p++) begin
                mcnt[p] = 0; mstag[p] = '0; mserr[p] = '0;
            end
            mlast = PORTS - 1; mv = 1'b0; maddr = '0; mlen = '0; mtag = '0; msv = '0;
        end else begin
            msv = '0;
            dec = 1'b0;
            sp  = 0;
            if (st_valid_in) begin
                sp = int'(st_tag_in[MTW-1:TW]);
                msv[sp]   = 1'b1;
                mstag[sp] = st_tag_in[TW-1:0];
                mserr[sp] = st_err_in;
                dec = (mcnt[sp] > 0);
            end
            if (dec) mcnt[sp] = mcnt[sp] - 1;
            if (g >= 0) begin
                mcnt[g] = mcnt[g] + 1;
                mv    = 1'b1;
                maddr = s_addr[g*AW +: AW];
                mlen  = s_len[g*LW +: LW];
                mtag  = {2'(g), s_tag[g*TW +: TW]};
                mlast = g;
            end else if (m_ready) begin
                mv = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle();
        s_valid = '0; m_ready = 1'b0; st_valid_in = 1'b0; st_tag_in = '0; st_err_in = '0;
        enable = 1'b1; rst = 1'b0;
    endtask

    task automatic rand_data();
        s_addr = {$urandom, $urandom};
        s_len  = 80'({$urandom, $urandom, $urandom});
        s_tag  = $urandom;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rand_data();
        rst = 1'b1; s_valid = 4'hF; m_ready = 1'b1;
        st_valid_in = 1'b1; st_tag_in = 10'h155;
        tick();
        #1;
        compared++;
        if (s_ready !== 4'b0000) begin
            mismatched++; $display("FAIL reset_ready: got %b want 0000", s_ready);
        end
        compared++;
        if ({m_valid, m_addr, m_len, m_tag} !== '0) begin
            mismatched++; $display("FAIL reset_mout: got v=%b a=%h l=%h t=%h want zeros",
                                   m_valid, m_addr, m_len, m_tag);
        end
        compared++;
        if ({st_valid_out, st_tag_out, st_err_out} !== '0) begin
            mismatched++; $display("FAIL reset_status: got v=%b t=%h e=%h want zeros",
                                   st_valid_out, st_tag_out, st_err_out);
        end
        tick();
        idle();
    endtask

    task automatic test_single();
        do_reset();
        rand_data();
        s_valid = 4'b0100; s_tag[23:16] = 8'h5A; s_addr[47:32] = 16'h1234; s_len[59:40] = 20'hABCDE;
        m_ready = 1'b1;
        #1;
        compared++;
        if (s_ready !== 4'b0100) begin
            mismatched++; $display("FAIL single_ready: got %b want 0100", s_ready);
        end
        tick();
        s_valid = '0;
        #1;
        compared++;
        if ({m_valid, m_tag, m_addr, m_len} !== {1'b1, 10'h25A, 16'h1234, 20'hABCDE}) begin
            mismatched++; $display("FAIL single_out: got v=%b t=%h a=%h l=%h want v=1 t=25a a=1234 l=abcde",
                                   m_valid, m_tag, m_addr, m_len);
        end
        tick();
        #1;
        compared++;
        if (m_valid !== 1'b0) begin
            mismatched++; $display("FAIL single_drain: got m_valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [TW-1:0] prev_tag;
        do_reset();
        s_valid = 4'hF; m_ready = 1'b1;
        prev_tag = '0;
        for (int k = 0; k < 12; k++) begin
            rand_data();
            #1;
            compared++;
            if (s_ready !== 4'(1 << (k % 4))) begin
                mismatched++; $display("FAIL rr_grant k=%0d: got %b want %b", k, s_ready, 4'(1 << (k % 4)));
            end
            if (k > 0) begin
                compared++;
                if ({m_valid, m_tag} !== {1'b1, 2'((k - 1) % 4), prev_tag}) begin
                    mismatched++; $display("FAIL rr_out k=%0d: got v=%b t=%h want v=1 t=%h",
                                           k, m_valid, m_tag, {2'((k - 1) % 4), prev_tag});
                end
            end
            prev_tag = s_tag[(k % 4)*TW +: TW];
            tick();
        end
        idle();
    endtask

    task automatic test_outstanding();
        int accepts;
        do_reset();
        rand_data();
        s_valid = 4'b0001; m_ready = 1'b1;
        accepts = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_ready[0]) accepts++;
            tick();
        end
        compared++;
        if (accepts !== MAXO) begin
            mismatched++; $display("FAIL cap_accepts: got %0d want %0d", accepts, MAXO);
        end
        st_valid_in = 1'b1; st_tag_in = {2'd0, 8'h77}; st_err_in = 4'h0;
        #1;
        compared++;
        if (s_ready !== 4'b0000) begin
            mismatched++; $display("FAIL cap_full_ready: got %b want 0000", s_ready);
        end
        tick();
        st_valid_in = 1'b0;
        #1;
        compared++;
        if ({st_valid_out, st_tag_out[7:0]} !== {4'b0001, 8'h77}) begin
            mismatched++; $display("FAIL cap_status: got v=%b t=%h want v=0001 t=77",
                                   st_valid_out, st_tag_out[7:0]);
        end
        accepts = 0;
        if (s_ready[0]) accepts++;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            if (s_ready[0]) accepts++;
            tick();
        end
        compared++;
        if (accepts !== 1) begin
            mismatched++; $display("FAIL cap_reopen: got %0d accepts want 1", accepts);
        end
        idle();
    endtask

    task automatic test_backpressure();
        logic [AW+LW+MTW-1:0] hold;
        do_reset();
        rand_data();
        s_valid = 4'hF; m_ready = 1'b0;
        #1;
        tick();
        #1;
        hold = {m_addr, m_len, m_tag};
        compared++;
        if ({m_valid, m_tag[9:8]} !== 3'b100) begin
            mismatched++; $display("FAIL bp_first: got v=%b port=%0d want v=1 port=0", m_valid, m_tag[9:8]);
        end
        for (int i = 0; i < 10; i++) begin
            rand_data();
            s_valid = 4'($urandom);
            #1;
            compared++;
            if ({s_ready, m_valid, m_addr, m_len, m_tag} !== {4'b0000, 1'b1, hold}) begin
                mismatched++; $display("FAIL bp_hold i=%0d: got r=%b v=%b d=%h want r=0000 v=1 d=%h",
                                       i, s_ready, m_valid, {m_addr, m_len, m_tag}, hold);
            end
            tick();
        end
        s_valid = 4'hF; m_ready = 1'b1;
        #1;
        compared++;
        if (s_ready !== 4'b0010) begin
            mismatched++; $display("FAIL bp_resume: got %b want 0010", s_ready);
        end
        tick();
        #1;
        compared++;
        if ({m_valid, m_tag[9:8]} !== 3'b101) begin
            mismatched++; $display("FAIL bp_next: got v=%b port=%0d want v=1 port=1", m_valid, m_tag[9:8]);
        end
        idle();
    endtask

    task automatic test_status();
        int accepts;
        do_reset();
        rand_data();
        s_valid = 4'b1000; m_ready = 1'b1;
        accepts = 0;
        for (int i = 0; i < 18; i++) begin
            #1;
            if (s_ready[3]) accepts++;
            tick();
        end
        compared++;
        if (accepts !== MAXO) begin
            mismatched++; $display("FAIL st_fill: got %0d accepts want %0d", accepts, MAXO);
        end
        st_valid_in = 1'b1; st_tag_in = {2'd3, 8'h11}; st_err_in = 4'h2;
        tick();
        st_valid_in = 1'b0;
        #1;
        compared++;
        if ({st_valid_out, st_tag_out[31:24], st_err_out[15:12]} !== {4'b1000, 8'h11, 4'h2}) begin
            mismatched++; $display("FAIL st_route: got v=%b t=%h e=%h want v=1000 t=11 e=2",
                                   st_valid_out, st_tag_out[31:24], st_err_out[15:12]);
        end
        compared++;
        if (s_ready !== 4'b1000) begin
            mismatched++; $display("FAIL st_dec: got %b want 1000", s_ready);
        end
        st_valid_in = 1'b1; st_tag_in = {2'd3, 8'h22}; st_err_in = 4'h5;
        tick();
        st_valid_in = 1'b0;
        #1;
        compared++;
        if ({st_valid_out, s_ready, st_tag_out[31:24]} !== {4'b1000, 4'b1000, 8'h22}) begin
            mismatched++; $display("FAIL st_same_cycle: got v=%b r=%b t=%h want v=1000 r=1000 t=22",
                                   st_valid_out, s_ready, st_tag_out[31:24]);
        end
        tick();
        #1;
        compared++;
        if ({st_valid_out, s_ready, st_tag_out[31:24], st_err_out[15:12]} !== {4'b0000, 4'b0000, 8'h22, 4'h5}) begin
            mismatched++; $display("FAIL st_hold: got v=%b r=%b t=%h e=%h want v=0000 r=0000 t=22 e=5",
                                   st_valid_out, s_ready, st_tag_out[31:24], st_err_out[15:12]);
        end
        idle();
    endtask

    task automatic test_enable_reset();
        do_reset();
        rand_data();
        s_valid = 4'hF; m_ready = 1'b0;
        #1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if ({s_ready, m_valid} !== 5'b00001) begin
                mismatched++; $display("FAIL en_hold i=%0d: got r=%b v=%b want r=0000 v=1", i, s_ready, m_valid);
            end
            tick();
        end
        m_ready = 1'b1;
        #1;
        compared++;
        if (s_ready !== 4'b0000) begin
            mismatched++; $display("FAIL en_drain_ready: got %b want 0000", s_ready);
        end
        tick();
        #1;
        compared++;
        if (m_valid !== 1'b0) begin
            mismatched++; $display("FAIL en_drained: got m_valid=%b want 0", m_valid);
        end
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1; st_valid_in = 1'b1; st_tag_in = {2'd1, 8'h3C}; st_err_in = 4'h7;
        #1;
        tick();
        rst = 1'b0; st_valid_in = 1'b0;
        #1;
        compared++;
        if ({m_valid, m_addr, st_valid_out, st_tag_out[15:8]} !== '0) begin
            mismatched++; $display("FAIL rst_mid: got v=%b a=%h sv=%b st=%h want all zero",
                                   m_valid, m_addr, st_valid_out, st_tag_out[15:8]);
        end
        compared++;
        if (s_ready !== 4'b0001) begin
            mismatched++; $display("FAIL rst_ptr: got %b want 0001", s_ready);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rand_data();
            rst         = ($urandom % 150 == 0);
            enable      = ($urandom % 8 != 0);
            m_ready     = ($urandom % 4 != 0);
            s_valid     = 4'($urandom);
            st_valid_in = ($urandom % 3 == 0);
            st_tag_in   = 10'($urandom);
            st_err_in   = 4'($urandom);
            #1;
            compared++;
            if (s_ready !== exp_ready()) begin
                mismatched++; $display("FAIL rand_ready c=%0d: got %b want %b", c, s_ready, exp_ready());
            end
            compared++;
            if (m_valid !== mv) begin
                mismatched++; $display("FAIL rand_mvalid c=%0d: got %b want %b", c, m_valid, mv);
            end
            if (mv) begin
                compared++;
                if ({m_addr, m_len, m_tag} !== {maddr, mlen, mtag}) begin
                    mismatched++; $display("FAIL rand_mdata c=%0d: got %h/%h/%h want %h/%h/%h",
                                           c, m_addr, m_len, m_tag, maddr, mlen, mtag);
                end
            end
            compared++;
            if (st_valid_out !== msv) begin
                mismatched++; $display("FAIL rand_svalid c=%0d: got %b want %b", c, st_valid_out, msv);
            end
            for (int p = 0; p < PORTS; p++) begin
                compared++;
                if ({st_tag_out[p*TW +: TW], st_err_out[p*4 +: 4]} !== {mstag[p], mserr[p]}) begin
                    mismatched++; $display("FAIL rand_sdata c=%0d p=%0d: got %h/%h want %h/%h",
                                           c, p, st_tag_out[p*TW +: TW], st_err_out[p*4 +: 4], mstag[p], mserr[p]);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int p = 0; p < PORTS; p++) begin
            mcnt[p] = 0; mstag[p] = '0; mserr[p] = '0;
        end
        mlast = PORTS - 1; mv = 1'b0; maddr = '0; mlen = '0; mtag = '0; msv = '0;
        s_addr = '0; s_len = '0; s_tag = '0;
        idle();
        rst = 1'b1;
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_outstanding();
        test_backpressure();
        test_status();
        test_enable_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
